// File: rtl/arima_pkg.sv
// Shared types and helpers for the ARIMA stream engine: FSM state encoding,
// default order limits and the saturation helpers used by every datapath stage.
package arima_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIFF  = 3'd1,
        MAC   = 3'd2,
        INTEG = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam int ARIMA_P_MAX = 10;
    localparam int ARIMA_Q_MAX = 10;
    localparam int ARIMA_D_MAX = 2;
    localparam int ARIMA_PW    = $clog2(ARIMA_P_MAX + 1);
    localparam int ARIMA_QW    = $clog2(ARIMA_Q_MAX + 1);
    localparam int ARIMA_DW    = $clog2(ARIMA_D_MAX + 1);
    localparam int ARIMA_TW    = $clog2(ARIMA_P_MAX + ARIMA_Q_MAX + 1);

    // Working width for intermediate sums; callers sign-extend into it.
    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat_lim(input int n);
        logic signed [SAT_W-1:0] one;
        one = SAT_W'(1);
        return (one <<< (n - 1)) - one;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_n(input logic signed [SAT_W-1:0] x,
                                                      input int n);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = sat_lim(n);
        lo = ~hi;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic logic sat_hit(input logic signed [SAT_W-1:0] x, input int n);
        logic signed [SAT_W-1:0] hi;
        hi = sat_lim(n);
        return (x > hi) || (x < ~hi);
    endfunction

endpackage

// File: rtl/arima_stream_engine_if.sv
// Sample-in / forecast-out stream bundle for the ARIMA engine.
// Both directions use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; a raised valid and its data stay stable until that edge.
interface arima_stream_engine_if #(parameter int N = 32);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [N-1:0] out_resid;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_resid
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_resid
    );
endinterface

// File: rtl/arima_mac.sv
// Single shared multiplier feeding an N+4 bit saturating accumulator.
// init loads the constant term; each en cycle adds floor(coef*operand / 2^FRAC).
module arima_mac
    import arima_pkg::*;
#(
    parameter int N    = 32,
    parameter int FRAC = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_init,
    input  logic [N-1:0] i_init_val,
    input  logic         i_en,
    input  logic [N-1:0] i_coef,
    input  logic [N-1:0] i_operand,
    output logic [N+3:0] o_acc,
    output logic         o_sat
);
    localparam int AW = N + 4;

    logic signed [2*N-1:0]   w_prod;
    logic signed [2*N-1:0]   w_shift;
    logic signed [SAT_W-1:0] w_sum;
    logic [AW-1:0]           r_acc;
    logic                    r_sat;

    always_comb begin
        w_prod  = $signed(i_coef) * $signed(i_operand);
        w_shift = w_prod >>> FRAC;
        w_sum   = SAT_W'(w_shift) + SAT_W'($signed(r_acc));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_init) begin
            r_acc <= AW'($signed(i_init_val));
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_acc <= AW'(sat_n(w_sum, AW));
            r_sat <= sat_hit(w_sum, AW);
        end else begin
            r_sat <= 1'b0;
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;
endmodule

// File: rtl/arima_stream_engine.sv
// One-step-ahead ARIMA(p,d,q) forecaster: differencing, time-shared AR/MA MAC,
// constant add and re-integration, sequenced by a single FSM per accepted sample.
module arima_stream_engine
    import arima_pkg::*;
#(
    parameter int N     = 32,
    parameter int FRAC  = 15,
    parameter int P_MAX = ARIMA_P_MAX,
    parameter int Q_MAX = ARIMA_Q_MAX,
    parameter int D_MAX = ARIMA_D_MAX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(P_MAX+1)-1:0]   cfg_p,
    input  logic [$clog2(D_MAX+1)-1:0]   cfg_d,
    input  logic [$clog2(Q_MAX+1)-1:0]   cfg_q,
    input  logic [P_MAX-1:0][N-1:0]      cfg_ar,
    input  logic [Q_MAX-1:0][N-1:0]      cfg_ma,
    input  logic [N-1:0]                 cfg_c,
    arima_stream_engine_if.slave         io,
    output logic                         sat_flag,
    output state_t                       o_dbg_state
);
    localparam int PW = $clog2(P_MAX + 1);
    localparam int QW = $clog2(Q_MAX + 1);
    localparam int DW = $clog2(D_MAX + 1);
    localparam int TW = $clog2(P_MAX + Q_MAX + 1);

    state_t                 r_state;
    logic                   r_in_ready, r_out_valid, r_sat_flag;
    logic [N-1:0]           r_out_data, r_out_resid;
    logic [N-1:0]           r_x, r_c, r_e_cur, r_what_prev;
    logic [PW-1:0]          r_p;
    logic [QW-1:0]          r_q;
    logic [DW-1:0]          r_d;
    logic [P_MAX-1:0][N-1:0] r_ar, r_w;
    logic [Q_MAX-1:0][N-1:0] r_ma, r_e;
    logic [D_MAX-1:0][N-1:0] r_lvl;
    logic [TW-1:0]          r_tap;

    logic [PW-1:0]          w_p_cl;
    logic [QW-1:0]          w_q_cl;
    logic [DW-1:0]          w_d_cl;
    logic [TW-1:0]          w_taps;
    logic [D_MAX:0][N-1:0]  w_dlv;
    logic [N-1:0]           w_w, w_e, w_what, w_yhat, w_coef, w_opnd;
    logic                   w_diff_sat, w_integ_sat, w_mac_sat;
    logic [N+3:0]           w_mac_acc;

    assign w_p_cl = (cfg_p > PW'(P_MAX)) ? PW'(P_MAX) : cfg_p;
    assign w_q_cl = (cfg_q > QW'(Q_MAX)) ? QW'(Q_MAX) : cfg_q;
    assign w_d_cl = (cfg_d > DW'(D_MAX)) ? DW'(D_MAX) : cfg_d;
    assign w_taps = TW'(r_p) + TW'(r_q);

    // Level k holds the k-th difference of the previous sample; w_dlv[k] is that of the current one.
    always_comb begin
        logic [N-1:0]            cur;
        logic signed [SAT_W-1:0] v;
        w_diff_sat = 1'b0;
        cur        = r_x;
        w_dlv[0]   = r_x;
        w_w        = r_x;
        for (int k = 1; k <= D_MAX; k++) begin
            v        = SAT_W'($signed(cur)) - SAT_W'($signed(r_lvl[k-1]));
            cur      = N'(sat_n(v, N));
            w_dlv[k] = cur;
            if (k <= int'(r_d)) begin
                w_w = cur;
                if (sat_hit(v, N)) w_diff_sat = 1'b1;
            end
        end
        v   = SAT_W'($signed(w_w)) - SAT_W'($signed(r_what_prev));
        w_e = N'(sat_n(v, N));
        if (sat_hit(v, N)) w_diff_sat = 1'b1;
    end

    // Tap t < p reads AR coefficient t against w history; later taps read MA against e history.
    always_comb begin
        w_coef = '0;
        w_opnd = '0;
        for (int i = 0; i < P_MAX; i++) begin
            if (r_tap == TW'(i) && TW'(i) < TW'(r_p)) begin
                w_coef = r_ar[i];
                w_opnd = r_w[i];
            end
        end
        for (int j = 0; j < Q_MAX; j++) begin
            if (r_tap == TW'(r_p) + TW'(j)) begin
                w_coef = r_ma[j];
                w_opnd = r_e[j];
            end
        end
    end

    always_comb begin
        logic signed [SAT_W-1:0] v;
        logic signed [SAT_W-1:0] s;
        logic [N-1:0]            what_v;
        v           = SAT_W'($signed(w_mac_acc));
        what_v      = N'(sat_n(v, N));
        w_integ_sat = sat_hit(v, N);
        s           = SAT_W'($signed(what_v));
        for (int k = 0; k < D_MAX; k++) begin
            if (k < int'(r_d)) s = s + SAT_W'($signed(r_lvl[k]));
        end
        w_yhat = N'(sat_n(s, N));
        if (sat_hit(s, N)) w_integ_sat = 1'b1;
        w_what = what_v;
    end

    arima_mac #(.N(N), .FRAC(FRAC)) u_mac (
        .clk        (clk),
        .rst        (rst),
        .i_init     (r_state == DIFF),
        .i_init_val (r_c),
        .i_en       (r_state == MAC),
        .i_coef     (w_coef),
        .i_operand  (w_opnd),
        .o_acc      (w_mac_acc),
        .o_sat      (w_mac_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_resid <= '0;
            r_sat_flag  <= 1'b0;
            r_x         <= '0;
            r_c         <= '0;
            r_e_cur     <= '0;
            r_what_prev <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_ar        <= '0;
            r_ma        <= '0;
            r_w         <= '0;
            r_e         <= '0;
            r_lvl       <= '0;
            r_tap       <= '0;
        end else begin
            r_sat_flag <= r_sat_flag | w_mac_sat
                        | ((r_state == DIFF) & w_diff_sat)
                        | ((r_state == INTEG) & w_integ_sat);
            case (r_state)
                IDLE: begin
                    if (r_in_ready && io.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_x        <= io.in_data;
                        r_p        <= w_p_cl;
                        r_q        <= w_q_cl;
                        r_d        <= w_d_cl;
                        r_ar       <= cfg_ar;
                        r_ma       <= cfg_ma;
                        r_c        <= cfg_c;
                        r_state    <= DIFF;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                DIFF: begin
                    for (int k = 0; k < D_MAX; k++) r_lvl[k] <= w_dlv[k];
                    r_w[0] <= w_w;
                    for (int i = 1; i < P_MAX; i++) r_w[i] <= r_w[i-1];
                    r_e[0] <= w_e;
                    for (int j = 1; j < Q_MAX; j++) r_e[j] <= r_e[j-1];
                    r_e_cur <= w_e;
                    r_tap   <= '0;
                    r_state <= (w_taps != '0) ? MAC : INTEG;
                end
                MAC: begin
                    r_tap <= r_tap + TW'(1);
                    if (r_tap + TW'(1) == w_taps) r_state <= INTEG;
                end
                INTEG: begin
                    r_what_prev <= w_what;
                    r_out_data  <= w_yhat;
                    r_out_resid <= r_e_cur;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (io.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = r_in_ready;
    assign io.out_valid = r_out_valid;
    assign io.out_data  = r_out_data;
    assign io.out_resid = r_out_resid;
    assign sat_flag     = r_sat_flag;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_arima_stream_engine.sv
// Directed bench for arima_stream_engine: hand-computed forecasts, residuals,
// latency, saturation, backpressure and mid-operation reset.
module tb_arima_stream_engine;
    import arima_pkg::*;

    localparam int N     = 32;
    localparam int P_MAX = 10;
    localparam int Q_MAX = 10;
    localparam int D_MAX = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [3:0]              cfg_p = '0;
    logic [1:0]              cfg_d = '0;
    logic [3:0]              cfg_q = '0;
    logic [P_MAX-1:0][N-1:0] cfg_ar = '0;
    logic [Q_MAX-1:0][N-1:0] cfg_ma = '0;
    logic [N-1:0]            cfg_c = '0;
    logic                    sat_flag;
    state_t                  dbg_state;

    int cmp_cnt = 0;
    int err_cnt = 0;

    arima_stream_engine_if #(.N(N)) io();

    arima_stream_engine #(.N(N), .FRAC(15), .P_MAX(P_MAX), .Q_MAX(Q_MAX), .D_MAX(D_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_p       (cfg_p),
        .cfg_d       (cfg_d),
        .cfg_q       (cfg_q),
        .cfg_ar      (cfg_ar),
        .cfg_ma      (cfg_ma),
        .cfg_c       (cfg_c),
        .io          (io),
        .sat_flag    (sat_flag),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] p, input logic [1:0] d, input logic [3:0] q,
                           input logic [N-1:0] c);
        cfg_p = p;
        cfg_d = d;
        cfg_q = q;
        cfg_c = c;
        cfg_ar = '0;
        cfg_ma = '0;
    endtask

    // Sends one sample, waits for its forecast and completes the output handshake.
    task automatic run_sample(input logic [N-1:0] x, output logic [N-1:0] data,
                              output logic [N-1:0] resid, output int lat, output bit to);
        int n;
        to = 1'b0; data = '0; resid = '0; lat = 0; n = 0;
        io.in_data = x;
        io.in_valid = 1'b1;
        while (!io.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!io.in_ready) begin io.in_valid = 1'b0; to = 1'b1; return; end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        while (!io.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!io.out_valid) begin to = 1'b1; return; end
        data = io.out_data;
        resid = io.out_resid;
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_cnt++; if (io.in_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_in_ready: got %b expected 0", io.in_ready); end
        cmp_cnt++; if (io.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
        cmp_cnt++; if (io.out_data !== 32'd0) begin err_cnt++; $display("FAIL reset_out_data: got %h expected 0", io.out_data); end
        cmp_cnt++; if (io.out_resid !== 32'd0) begin err_cnt++; $display("FAIL reset_out_resid: got %h expected 0", io.out_resid); end
        cmp_cnt++; if (sat_flag !== 1'b0) begin err_cnt++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
        cmp_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        cmp_cnt++; if (io.in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready_after: got %b expected 1", io.in_ready); end
    endtask

    task automatic test_ar_only(input string tag);
        logic [N-1:0] d, r; int lat; bit to;
        set_cfg(4'd1, 2'd0, 4'd0, 32'd0);
        cfg_ar[0] = 32'd16384;
        run_sample(32'd32768, d, r, lat, to);
        cmp_cnt++; if (to) begin err_cnt++; $display("FAIL %s_timeout: got timeout expected forecast", tag); end
        cmp_cnt++; if (d !== 32'd16384) begin err_cnt++; $display("FAIL %s_data: got %0d expected 16384", tag, d); end
        cmp_cnt++; if (r !== 32'd32768) begin err_cnt++; $display("FAIL %s_resid: got %0d expected 32768", tag, r); end
        cmp_cnt++; if (lat != 3) begin err_cnt++; $display("FAIL %s_latency: got %0d expected 3", tag, lat); end
        cmp_cnt++; if (sat_flag !== 1'b0) begin err_cnt++; $display("FAIL %s_sat: got %b expected 0", tag, sat_flag); end
    endtask

    task automatic test_integration();
        int xs[3] = '{100, 300, 600};
        int ed[3] = '{110, 310, 610};
        int er[3] = '{100, 190, 290};
        logic [N-1:0] d, r; int lat; bit to;
        do_reset();
        set_cfg(4'd0, 2'd1, 4'd0, 32'd10);
        for (int i = 0; i < 3; i++) begin
            run_sample(xs[i], d, r, lat, to);
            cmp_cnt++; if (to) begin err_cnt++; $display("FAIL integ_timeout[%0d]: got timeout expected forecast", i); end
            cmp_cnt++; if (d !== 32'(ed[i])) begin err_cnt++; $display("FAIL integ_data[%0d]: got %0d expected %0d", i, $signed(d), ed[i]); end
            cmp_cnt++; if (r !== 32'(er[i])) begin err_cnt++; $display("FAIL integ_resid[%0d]: got %0d expected %0d", i, $signed(r), er[i]); end
            cmp_cnt++; if (lat != 2) begin err_cnt++; $display("FAIL integ_latency[%0d]: got %0d expected 2", i, lat); end
        end
    endtask

    task automatic test_diff2_clamp();
        int xs[3] = '{10, 30, 60};
        int ed[3] = '{20, 50, 90};
        logic [N-1:0] d, r; int lat; bit to;
        do_reset();
        set_cfg(4'd0, 2'd3, 4'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            run_sample(xs[i], d, r, lat, to);
            cmp_cnt++; if (to) begin err_cnt++; $display("FAIL diff2_timeout[%0d]: got timeout expected forecast", i); end
            cmp_cnt++; if (d !== 32'(ed[i])) begin err_cnt++; $display("FAIL diff2_data[%0d]: got %0d expected %0d", i, $signed(d), ed[i]); end
            cmp_cnt++; if (r !== 32'd10) begin err_cnt++; $display("FAIL diff2_resid[%0d]: got %0d expected 10", i, $signed(r)); end
        end
    endtask

    task automatic test_ma();
        int xs[2] = '{1000, 2000};
        int ed[2] = '{500, 750};
        int er[2] = '{1000, 1500};
        logic [N-1:0] d, r; int lat; bit to;
        do_reset();
        set_cfg(4'd0, 2'd0, 4'd1, 32'd0);
        cfg_ma[0] = 32'd16384;
        for (int i = 0; i < 2; i++) begin
            run_sample(xs[i], d, r, lat, to);
            cmp_cnt++; if (to) begin err_cnt++; $display("FAIL ma_timeout[%0d]: got timeout expected forecast", i); end
            cmp_cnt++; if (d !== 32'(ed[i])) begin err_cnt++; $display("FAIL ma_data[%0d]: got %0d expected %0d", i, $signed(d), ed[i]); end
            cmp_cnt++; if (r !== 32'(er[i])) begin err_cnt++; $display("FAIL ma_resid[%0d]: got %0d expected %0d", i, $signed(r), er[i]); end
        end
    endtask

    // p=2, q=1 with nonzero coefficients beyond the selected orders that must be ignored.
    task automatic test_mixed();
        int xs[3] = '{1000, 2000, 500};
        int ed[3] = '{1100, 1800, 200};
        int er[3] = '{1000, 900, -1300};
        logic [N-1:0] d, r; int lat; bit to;
        do_reset();
        set_cfg(4'd2, 2'd0, 4'd1, 32'd100);
        cfg_ar[0] = 32'd16384;
        cfg_ar[1] = 32'd8192;
        cfg_ar[2] = 32'd32768;
        cfg_ma[0] = 32'd16384;
        cfg_ma[1] = 32'd32768;
        for (int i = 0; i < 3; i++) begin
            run_sample(xs[i], d, r, lat, to);
            cmp_cnt++; if (to) begin err_cnt++; $display("FAIL mixed_timeout[%0d]: got timeout expected forecast", i); end
            cmp_cnt++; if (d !== 32'(ed[i])) begin err_cnt++; $display("FAIL mixed_data[%0d]: got %0d expected %0d", i, $signed(d), ed[i]); end
            cmp_cnt++; if (r !== 32'(er[i])) begin err_cnt++; $display("FAIL mixed_resid[%0d]: got %0d expected %0d", i, $signed(r), er[i]); end
            cmp_cnt++; if (lat != 5) begin err_cnt++; $display("FAIL mixed_latency[%0d]: got %0d expected 5", i, lat); end
        end
    endtask

    task automatic test_order_clamp();
        logic [N-1:0] d, r; int lat; bit to;
        do_reset();
        set_cfg(4'd15, 2'd0, 4'd15, 32'd7);
        run_sample(32'd5, d, r, lat, to);
        cmp_cnt++; if (to) begin err_cnt++; $display("FAIL clamp_timeout: got timeout expected forecast"); end
        cmp_cnt++; if (d !== 32'd7) begin err_cnt++; $display("FAIL clamp_data: got %0d expected 7", d); end
        cmp_cnt++; if (r !== 32'd5) begin err_cnt++; $display("FAIL clamp_resid: got %0d expected 5", r); end
        cmp_cnt++; if (lat != 22) begin err_cnt++; $display("FAIL clamp_latency: got %0d expected 22", lat); end
    endtask

    task automatic test_saturation();
        logic [N-1:0] d, r; int lat; bit to;
        do_reset();
        set_cfg(4'd1, 2'd0, 4'd0, 32'd0);
        cfg_ar[0] = 32'd65536;
        cmp_cnt++; if (sat_flag !== 1'b0) begin err_cnt++; $display("FAIL sat_initial: got %b expected 0", sat_flag); end
        run_sample(32'h7FFF_FFFF, d, r, lat, to);
        cmp_cnt++; if (to) begin err_cnt++; $display("FAIL sat_timeout: got timeout expected forecast"); end
        cmp_cnt++; if (d !== 32'h7FFF_FFFF) begin err_cnt++; $display("FAIL sat_data: got %h expected 7fffffff", d); end
        cmp_cnt++; if (r !== 32'h7FFF_FFFF) begin err_cnt++; $display("FAIL sat_resid: got %h expected 7fffffff", r); end
        cmp_cnt++; if (sat_flag !== 1'b1) begin err_cnt++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
        run_sample(32'd100, d, r, lat, to);
        cmp_cnt++; if (d !== 32'd200) begin err_cnt++; $display("FAIL sat_next_data: got %0d expected 200", d); end
        cmp_cnt++; if (r !== 32'h8000_0065) begin err_cnt++; $display("FAIL sat_next_resid: got %h expected 80000065", r); end
        cmp_cnt++; if (sat_flag !== 1'b1) begin err_cnt++; $display("FAIL sat_flag_sticky: got %b expected 1", sat_flag); end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        set_cfg(4'd1, 2'd0, 4'd0, 32'd0);
        cfg_ar[0] = 32'd16384;
        io.out_ready = 1'b0;
        io.in_data = 32'd32768;
        io.in_valid = 1'b1;
        n = 0;
        while (!io.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk);
        #1;
        io.in_data = 32'd64;
        n = 0;
        while (!io.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        cmp_cnt++; if (io.out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_first_valid: got %b expected 1", io.out_valid); end
        for (int i = 0; i < 5; i++) begin
            cmp_cnt++; if (io.out_data !== 32'd16384) begin err_cnt++; $display("FAIL bp_hold_data[%0d]: got %0d expected 16384", i, io.out_data); end
            cmp_cnt++; if (io.out_resid !== 32'd32768) begin err_cnt++; $display("FAIL bp_hold_resid[%0d]: got %0d expected 32768", i, io.out_resid); end
            cmp_cnt++; if (io.in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, io.in_ready); end
            cmp_cnt++; if (io.out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, io.out_valid); end
            @(posedge clk);
            #1;
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cmp_cnt++; if (io.out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_valid_drop: got %b expected 0", io.out_valid); end
        cmp_cnt++; if (io.in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_return: got %b expected 1", io.in_ready); end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        n = 0;
        while (!io.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        cmp_cnt++; if (n != 3) begin err_cnt++; $display("FAIL bp_second_latency: got %0d expected 3", n); end
        cmp_cnt++; if (io.out_data !== 32'd32) begin err_cnt++; $display("FAIL bp_second_data: got %0d expected 32", io.out_data); end
        cmp_cnt++; if (io.out_resid !== 32'hFFFF_C040) begin err_cnt++; $display("FAIL bp_second_resid: got %0d expected -16320", $signed(io.out_resid)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mac();
        int n;
        bit seen;
        do_reset();
        set_cfg(4'd5, 2'd0, 4'd5, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cfg_ar[i] = 32'd16384;
            cfg_ma[i] = 32'd16384;
        end
        io.in_data = 32'd1000;
        io.in_valid = 1'b1;
        n = 0;
        while (!io.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_cnt++; if (dbg_state !== MAC) begin err_cnt++; $display("FAIL midrst_in_mac: got %0d expected %0d", dbg_state, MAC); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL midrst_state: got %0d expected %0d", dbg_state, IDLE); end
        cmp_cnt++; if (io.out_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_out_valid: got %b expected 0", io.out_valid); end
        @(posedge clk);
        #1;
        cmp_cnt++; if (io.in_ready !== 1'b1) begin err_cnt++; $display("FAIL midrst_in_ready: got %b expected 1", io.in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (io.out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        cmp_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL midrst_no_output: got %b expected 0", seen); end
        test_ar_only("replay");
    endtask

    initial begin
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.out_ready = 1'b1;
        test_reset();
        test_ar_only("ar_only");
        test_integration();
        test_diff2_clamp();
        test_ma();
        test_mixed();
        test_order_clamp();
        test_saturation();
        test_backpressure();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
